// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - shared constants for the arbitrated logic unit
package logic_unit_arbiter_pkg;

    localparam int LUA_WIDTH = 32;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOR = 2'b11;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/logic_unit32.sv
// rtl/logic_unit32.sv - combinational bitwise logic unit (AND/OR/XOR/NOR)
module logic_unit32
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = LUA_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Pure bitwise function: no carries, no flags.
    always_comb begin
        y = '0;
        case (op)
            LOP_AND: y = a & b;
            LOP_OR:  y = a | b;
            LOP_XOR: y = a ^ b;
            LOP_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one logic unit between two requesters
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = LUA_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_id,
    output logic [CNT_W-1:0]   cnt0,
    output logic [CNT_W-1:0]   cnt1
);

    logic [0:0]       slot_state;
    logic             last;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [1:0]       gnt_op;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;
    logic [WIDTH-1:0] lu_y;

    assign rsp_valid  = (slot_state == SLOT_FULL);
    assign can_accept = (slot_state == SLOT_EMPTY) || rsp_ready;

    // Grant selection: a lone requester wins; on conflict the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req_valid[1];
        end
    end

    // Only the granted requester sees ready, and only when the slot can take a result.
    always_comb begin
        req_ready = 2'b00;
        if (can_accept && (req_valid != 2'b00)) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Operand mux feeding the single shared logic unit.
    always_comb begin
        gnt_op = req_op[1:0];
        gnt_a  = req_a[WIDTH-1:0];
        gnt_b  = req_b[WIDTH-1:0];
        if (grant) begin
            gnt_op = req_op[3:2];
            gnt_a  = req_a[2*WIDTH-1:WIDTH];
            gnt_b  = req_b[2*WIDTH-1:WIDTH];
        end
    end

    logic_unit32 #(.WIDTH(WIDTH)) u_lu (
        .op (gnt_op),
        .a  (gnt_a),
        .b  (gnt_b),
        .y  (lu_y)
    );

    // Result slot: load on accept, empty on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_state <= SLOT_EMPTY;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else if (accept) begin
            slot_state <= SLOT_FULL;
            rsp_data   <= lu_y;
            rsp_id     <= grant;
        end else if ((slot_state == SLOT_FULL) && rsp_ready) begin
            slot_state <= SLOT_EMPTY;
        end
    end

    // Round-robin pointer; reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant;
        end
    end

    // Saturating per-requester accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (!grant && (cnt0 != {CNT_W{1'b1}})) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (grant && (cnt1 != {CNT_W{1'b1}})) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_ready;

    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    logic [1:0]  s_req_ready;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_data;
    logic        s_rsp_id;
    logic [1:0]  s_cnt0;
    logic [1:0]  s_cnt1;

    int n_vec;
    int n_err;

    logic [1:0]  exp_gnt [4];
    logic [31:0] exp_dat [4];

    logic_unit_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    logic_unit_arbiter #(.WIDTH(32), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (s_req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (s_rsp_data),
        .rsp_id    (s_rsp_id),
        .cnt0      (s_cnt0),
        .cnt1      (s_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[i*2 +: 2]  = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_data", rsp_data, 32'h0);
        check("rst_id", rsp_id, 1'b0);
        check("rst_cnt0", cnt0, 16'd0);
        check("rst_cnt1", cnt1, 16'd0);
        check("rst_ready", req_ready, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        // Single OR op on requester 0
        set_req(0, 2'b01, 32'hFFDF1F40, 32'h80031F4F);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        check("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("single_valid", rsp_valid, 1'b1);
        check("single_data", rsp_data, 32'hFFDF1F4F);
        check("single_id", rsp_id, 1'b0);
        check("single_cnt0", cnt0, 16'd1);

        // Ops sweep on requester 1, back to back
        req_valid = 2'b10;
        set_req(1, 2'b00, 32'hFFDF1F40, 32'h80031F4F);
        tick();
        check("and_data", rsp_data, 32'h80031F40);
        check("and_id", rsp_id, 1'b1);
        set_req(1, 2'b10, 32'hFFDF1F40, 32'h80031F4F);
        tick();
        check("xor_data", rsp_data, 32'h7FDC000F);
        check("xor_id", rsp_id, 1'b1);
        set_req(1, 2'b11, 32'h0, 32'h0);
        tick();
        check("nor_data", rsp_data, 32'hFFFFFFFF);
        check("nor_id", rsp_id, 1'b1);
        check("sweep_cnt1", cnt1, 16'd3);
        req_valid = 2'b00;
        tick();
        check("drain_valid", rsp_valid, 1'b0);

        // Contention: both valid for 4 cycles
        set_req(0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        set_req(1, 2'b10, 32'h12345678, 32'hFFFFFFFF);
        exp_gnt[0] = 2'b01; exp_dat[0] = 32'hF000F000;
        exp_gnt[1] = 2'b10; exp_dat[1] = 32'hEDCBA987;
        exp_gnt[2] = 2'b01; exp_dat[2] = 32'hF000F000;
        exp_gnt[3] = 2'b10; exp_dat[3] = 32'hEDCBA987;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont_ready%0d", k), req_ready, exp_gnt[k]);
            tick();
            check($sformatf("cont_valid%0d", k), rsp_valid, 1'b1);
            check($sformatf("cont_id%0d", k), rsp_id, exp_gnt[k][1]);
            check($sformatf("cont_data%0d", k), rsp_data, exp_dat[k]);
        end
        check("cont_cnt0", cnt0, 16'd3);
        check("cont_cnt1", cnt1, 16'd5);

        // Backpressure: slot full, consumer stalled, both still requesting
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready%0d", k), req_ready, 2'b00);
            tick();
            check($sformatf("bp_data%0d", k), rsp_data, 32'hEDCBA987);
            check($sformatf("bp_valid%0d", k), rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 2'b01);
        tick();
        check("bp_new_valid", rsp_valid, 1'b1);
        check("bp_new_id", rsp_id, 1'b0);
        check("bp_new_data", rsp_data, 32'hF000F000);
        check("bp_cnt0", cnt0, 16'd4);

        // Asynchronous reset while holding a result
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", rsp_valid, 1'b0);
        check("arst_cnt0", cnt0, 16'd0);
        check("arst_cnt1", cnt1, 16'd0);
        check("arst_data", rsp_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        check("arst_first_ready", req_ready, 2'b01);
        tick();
        check("arst_first_id", rsp_id, 1'b0);
        check("arst_first_cnt0", cnt0, 16'd1);
        check("arst_first_cnt1", cnt1, 16'd0);

        // Counter saturation with a 2-bit counter
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        req_valid = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            set_req(0, 2'b10, 32'h0, 32'(k));
            tick();
            check($sformatf("sat_valid%0d", k), s_rsp_valid, 1'b1);
            check($sformatf("sat_data%0d", k), s_rsp_data, 64'(k));
            check($sformatf("sat_id%0d", k), s_rsp_id, 1'b0);
        end
        check("sat_cnt0", s_cnt0, 2'd3);
        check("sat_wide_cnt0", cnt0, 16'd5);
        req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
